// File: rtl/apb_rr_master_if.sv
// APB bus bundle between apb_rr_master and the downstream APB slave decoder.
interface apb_rr_master_if;
    logic [31:0] m_apb_paddr;
    logic        m_apb_psel;
    logic        m_apb_penable;
    logic        m_apb_pwrite;
    logic [31:0] m_apb_pwdata;
    logic [3:0]  m_apb_pstrb;
    logic [2:0]  m_apb_pprot;
    logic        m_apb_pready;
    logic [31:0] m_apb_prdata;
    logic        m_apb_pslverr;

    modport master (
        output m_apb_paddr, m_apb_psel, m_apb_penable, m_apb_pwrite,
               m_apb_pwdata, m_apb_pstrb, m_apb_pprot,
        input  m_apb_pready, m_apb_prdata, m_apb_pslverr
    );

    modport slave (
        input  m_apb_paddr, m_apb_psel, m_apb_penable, m_apb_pwrite,
               m_apb_pwdata, m_apb_pstrb, m_apb_pprot,
        output m_apb_pready, m_apb_prdata, m_apb_pslverr
    );
endinterface

// File: rtl/apb_rr_master.sv
// Round-robin arbitrated APB master shared by NUM_REQ on-chip requesters.
// Define APB_RR_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT cycles.
module apb_rr_master #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 16,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   s_axi_clk,
    input  logic                   s_axi_aresetn,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [NUM_REQ*32-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0]  req_wdata,
    input  logic [NUM_REQ*4-1:0]   req_strb,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic [IDX_W-1:0]       grant_idx,
    apb_rr_master_if.master        m_apb
);

    if (NUM_REQ < 1 || NUM_REQ > 16 || TIMEOUT < 1) begin : g_bad_param
        $error("apb_rr_master: NUM_REQ must be 1..16 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [31:0]          paddr_q, paddr_d;
    logic [31:0]          pwdata_q, pwdata_d;
    logic                 pwrite_q, pwrite_d;
    logic [3:0]           pstrb_q, pstrb_d;
    logic                 psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [NUM_REQ-1:0]   ready_c;
    logic                 found;
    logic [IDX_W-1:0]     win;
    logic [IDX_W-1:0]     cand;

`ifdef APB_RR_TIMEOUT_EN
    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0]            cnt_q, cnt_d;
`endif

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return IDX_W'(v % NUM_REQ);
    endfunction

    // Scan upward from ptr with wrap; the first asserted request wins.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        cand  = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = wrap_idx(int'(ptr_q) + i);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        pstrb_d     = pstrb_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        ready_c     = '0;
`ifdef APB_RR_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    ready_c[win] = 1'b1;
                    grant_d      = win;
                    paddr_d      = req_addr[{win, 5'b00000} +: 32];
                    pwdata_d     = req_wdata[{win, 5'b00000} +: 32];
                    pwrite_d     = req_write[win];
                    pstrb_d      = req_write[win] ? req_strb[{win, 2'b00} +: 4] : 4'h0;
                    psel_d       = 1'b1;
                    penable_d    = 1'b0;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_RR_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (m_apb.m_apb_pready) begin
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    rsp_rdata_d          = pwrite_q ? 32'h0 : m_apb.m_apb_prdata;
                    rsp_err_d            = m_apb.m_apb_pslverr;
                    rsp_valid_d[grant_q] = 1'b1;
                    ptr_d                = wrap_idx(int'(grant_q) + 1);
                    state_d              = IDLE;
                end
`ifdef APB_RR_TIMEOUT_EN
                // Last allowed ACCESS cycle without pready: abort as an error.
                else if (cnt_q == TO_LAST) begin
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    rsp_rdata_d          = 32'h0;
                    rsp_err_d            = 1'b1;
                    rsp_valid_d[grant_q] = 1'b1;
                    ptr_d                = wrap_idx(int'(grant_q) + 1);
                    state_d              = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            pstrb_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_RR_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            pstrb_q     <= pstrb_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_RR_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // The accept strobe is combinational, so keep it quiet while reset is held.
    assign req_ready           = ready_c & {NUM_REQ{s_axi_aresetn}};
    assign rsp_valid           = rsp_valid_q;
    assign rsp_rdata           = rsp_rdata_q;
    assign rsp_err             = rsp_err_q;
    assign grant_idx           = grant_q;
    assign m_apb.m_apb_paddr   = paddr_q;
    assign m_apb.m_apb_psel    = psel_q;
    assign m_apb.m_apb_penable = penable_q;
    assign m_apb.m_apb_pwrite  = pwrite_q;
    assign m_apb.m_apb_pwdata  = pwdata_q;
    assign m_apb.m_apb_pstrb   = pstrb_q;
    assign m_apb.m_apb_pprot   = 3'b000;

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Multi-requester APB master.
- Shares one APB bus between NUM_REQ internal requesters using round-robin arbitration.
- Sequences each transfer through the APB SETUP/ACCESS phases and returns the response to the granted requester.
- Sits between the AXI-Lite bridge core plus other on-chip initiators and the APB slave decoder.

Parameters:
NUM_REQ, 2, number of requesters (1..16); request-side buses are packed, requester i occupies slice i
TIMEOUT, 16, ACCESS-phase cycle limit; used only with APB_RR_TIMEOUT_EN; must be >=1
IDX_W, $clog2(NUM_REQ) (min 1), width of grant index and RR pointer

Ports:
s_axi_clk  in  1  clock
s_axi_aresetn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  transfer request; held stable until accepted
req_ready  out  NUM_REQ  accept strobe (one-hot, combinational, IDLE only)
req_write  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*32  transfer address
req_wdata  in  NUM_REQ*32  write data
req_strb  in  NUM_REQ*4  write byte strobes
rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester
rsp_rdata  out  32  read data (0 for writes); holds until the next completion
rsp_err  out  1  1 = slave error or timeout; valid with rsp_valid
grant_idx  out  IDX_W  index of the current/last granted requester
m_apb_paddr  out  32  APB address
m_apb_psel  out  1  APB select (single; slave decode is downstream)
m_apb_penable  out  1  APB enable
m_apb_pwrite  out  1  APB direction
m_apb_pwdata  out  32  APB write data
m_apb_pstrb  out  4  APB strobes; forced 0 on reads
m_apb_pprot  out  3  tied 3'b000
m_apb_pready  in  1  slave ready
m_apb_prdata  in  32  slave read data
m_apb_pslverr  in  1  slave error

Behaviour:
- FSM states: IDLE, SETUP, ACCESS. Reset state is IDLE.
- Reset values: ptr=0; all outputs 0.
- IDLE, arbitration:
  - If any req_valid, the winner is the first set bit scanning upward from ptr, wrapping at NUM_REQ.
  - req_ready[winner]=1 in that cycle.
  - Latch addr, wdata, write and strb (strb=0 if read); grant_idx=winner.
  - Next state SETUP. With no request, stay in IDLE.
- SETUP: psel=1, penable=0. Next state ACCESS, unconditionally.
- ACCESS: psel=1, penable=1. Hold until pready=1. On pready:
  - rsp_rdata <= prdata for reads, 0 for writes.
  - rsp_err <= pslverr.
  - rsp_valid[grant_idx] pulses in the next cycle.
  - ptr <= (grant_idx+1) mod NUM_REQ.
  - Next state IDLE.
- Registered APB outputs: psel and penable deassert in IDLE. paddr, pwrite, pwdata and pstrb hold their last values.
- Throughput: minimum 3 cycles per transfer (IDLE, SETUP, ACCESS). The rsp_valid pulse coincides with the IDLE cycle in which the next grant may be issued.
- ptr advances only on completion, never on acceptance.
- A requester whose req_valid is not set when scanned is skipped.
- req_valid dropping before acceptance is legal (request withdrawn). req_valid changing after acceptance is ignored.
- A requester must not issue a new request before its rsp_valid. The block does not check this.
- Reset mid-transfer: psel and penable drop immediately (asynchronous). No rsp_valid is issued. The transfer is lost and ptr returns to 0.
- NUM_REQ=1 degenerates to a plain APB master with the same timing.

Optional Feature:
- APB_RR_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT+1) clears on SETUP and increments each ACCESS cycle with pready=0.
  - If ACCESS has lasted TIMEOUT cycles without pready: drop psel/penable, rsp_err=1, rsp_rdata=0, pulse rsp_valid, advance ptr, go to IDLE.
  - pready=1 in the limit cycle wins (normal completion).
- APB_RR_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for pready.

Test Plan:
- Req0 read 0x10, pready=1 immediately, prdata=0xDEADBEEF -> psel=1 from cycle 1, penable in cycle 2; rsp_valid[0] in cycle 3 with rsp_rdata=0xDEADBEEF, rsp_err=0, pstrb=0.
- Req0 and req1 both request continuously with ptr=0 -> grant order 0,1,0,1; each transfer takes 3 cycles; rsp_valid goes to the matching requester.
- Req1 write 0x24, data 0x12345678, strb 4'h3; slave inserts 2 wait states with pslverr=1 -> pwdata/pstrb match; ACCESS lasts 3 cycles; rsp_valid[1] with rsp_err=1, rsp_rdata=0.
- Reset asserted during ACCESS -> psel=penable=0 immediately, no rsp_valid; after release, simultaneous req0 and req1 grant req0 first.
- Req0 withdraws req_valid before acceptance while req1 is pending -> req1 granted; req0 receives no req_ready.
- TIMEOUT=16 with pready stuck at 0 -> with APB_RR_TIMEOUT_EN: rsp_err=1 after 16 ACCESS cycles, then IDLE. Without it: still in ACCESS after 100 cycles.
